// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcodes and the decoded issue bundle.
// Included by the decode stage and by the ALU itself.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    // ALU_Control = {class[1:0], alt, funct3}
    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SLL  = 6'b000001;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_SRL  = 6'b000101;
    localparam logic [5:0] ALU_OR   = 6'b000110;
    localparam logic [5:0] ALU_AND  = 6'b000111;
    localparam logic [5:0] ALU_SUB  = 6'b001000;
    localparam logic [5:0] ALU_SRA  = 6'b001101;
    localparam logic [5:0] ALU_BEQ  = 6'b010000;
    localparam logic [5:0] ALU_BNE  = 6'b010001;
    localparam logic [5:0] ALU_BLT  = 6'b010100;
    localparam logic [5:0] ALU_BGE  = 6'b010101;
    localparam logic [5:0] ALU_BLTU = 6'b010110;
    localparam logic [5:0] ALU_BGEU = 6'b010111;
    localparam logic [5:0] ALU_JALR = 6'b111111;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [5:0]      alu_ctrl;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            reg_write;
        logic            branch_op;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } decoded_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decoder: instruction, PC and register data in, ALU issue bundle out.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output decoded_t        o_bundle
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_shamt;
    logic            w_is_shift;
    logic            w_writes;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_imm_i    = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s    = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b    = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
    assign w_imm_u    = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
    assign w_imm_j    = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
    assign w_shamt    = {{(XLEN-5){1'b0}}, i_instr[24:20]};
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    always_comb begin
        o_bundle    = '0;
        o_bundle.pc = i_pc;
        w_writes    = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                o_bundle.alu_ctrl = {2'b00, i_instr[30], w_funct3};
                o_bundle.op_a     = i_rs1_data;
                o_bundle.op_b     = i_rs2_data;
                w_writes          = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only SRLI/SRAI take alt from bit 30; elsewhere it is immediate data.
                o_bundle.alu_ctrl = {2'b00, (w_funct3 == 3'b101) && i_instr[30], w_funct3};
                o_bundle.op_a     = i_rs1_data;
                o_bundle.op_b     = w_is_shift ? w_shamt : w_imm_i;
                o_bundle.imm      = w_imm_i;
                w_writes          = 1'b1;
            end
            OPC_LOAD: begin
                o_bundle.alu_ctrl = ALU_ADD;
                o_bundle.op_a     = i_rs1_data;
                o_bundle.op_b     = w_imm_i;
                o_bundle.imm      = w_imm_i;
                o_bundle.mem_read = 1'b1;
                w_writes          = 1'b1;
            end
            OPC_STORE: begin
                o_bundle.alu_ctrl  = ALU_ADD;
                o_bundle.op_a      = i_rs1_data;
                o_bundle.op_b      = w_imm_s;
                o_bundle.imm       = w_imm_s;
                o_bundle.mem_write = 1'b1;
            end
            OPC_LUI: begin
                o_bundle.alu_ctrl = ALU_ADD;
                o_bundle.op_b     = w_imm_u;
                o_bundle.imm      = w_imm_u;
                w_writes          = 1'b1;
            end
            OPC_AUIPC: begin
                o_bundle.alu_ctrl = ALU_ADD;
                o_bundle.op_a     = i_pc;
                o_bundle.op_b     = w_imm_u;
                o_bundle.imm      = w_imm_u;
                w_writes          = 1'b1;
            end
            OPC_BRANCH: begin
                o_bundle.alu_ctrl  = {3'b010, w_funct3};
                o_bundle.op_a      = i_rs1_data;
                o_bundle.op_b      = i_rs2_data;
                o_bundle.imm       = w_imm_b;
                o_bundle.branch_op = 1'b1;
            end
            OPC_JAL: begin
                o_bundle.alu_ctrl = ALU_JALR;
                o_bundle.op_a     = i_pc + XLEN'(4);
                o_bundle.op_b     = w_imm_j;
                o_bundle.imm      = w_imm_j;
                w_writes          = 1'b1;
            end
            OPC_JALR: begin
                o_bundle.alu_ctrl = ALU_JALR;
                o_bundle.op_a     = i_pc + XLEN'(4);
                o_bundle.op_b     = w_imm_i;
                o_bundle.imm      = w_imm_i;
                w_writes          = 1'b1;
            end
            default: begin
                o_bundle.illegal = 1'b1;
            end
        endcase
        o_bundle.rd        = w_writes ? i_instr[11:7] : 5'd0;
        o_bundle.reg_write = w_writes && (i_instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode/issue stage in front of the ALU with valid/ready handshake and flush.
// Define ALU_DECODE_SKID_EN to add a skid entry and a registered in_ready.
module alu_decode_stage
    import alu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      ALU_Control,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic            branch_op,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            illegal
);

    decoded_t w_dec;
    decoded_t r_out;
    logic     r_out_valid;
    logic     w_in_fire;

    alu_decoder u_decoder (
        .i_instr    (instr),
        .i_pc       (pc),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_bundle   (w_dec)
    );

`ifdef ALU_DECODE_SKID_EN
    decoded_t r_skid;
    logic     r_skid_valid;
    logic     w_out_free;

    // in_ready comes straight from the skid flop, so out_ready never reaches it.
    assign in_ready   = !r_skid_valid;
    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready  = !r_out_valid || out_ready;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (in_ready) begin
            r_out_valid <= in_valid;
            if (w_in_fire) begin
                r_out <= w_dec;
            end
        end
    end
`endif

    assign out_valid   = r_out_valid;
    assign ALU_Control = r_out.alu_ctrl;
    assign operand_A   = r_out.op_a;
    assign operand_B   = r_out.op_b;
    assign branch_op   = r_out.branch_op;
    assign imm         = r_out.imm;
    assign pc_out      = r_out.pc;
    assign rd          = r_out.rd;
    assign reg_write   = r_out.reg_write;
    assign mem_read    = r_out.mem_read;
    assign mem_write   = r_out.mem_write;
    assign illegal     = r_out.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: decode vector table plus stall, flush and reset sequences.
module tb_alu_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic        branch_op;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    alu_decode_stage dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_Control (ALU_Control),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .branch_op   (branch_op),
        .imm         (imm),
        .pc_out      (pc_out),
        .rd          (rd),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        mr;
        logic        mw;
        logic        ill;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] snapshot();
        return {out_valid, ALU_Control, operand_A, operand_B, imm, pc_out, rd,
                reg_write, branch_op, mem_read, mem_write, illegal};
    endfunction

    function automatic logic [31:0] addi_instr(input int k);
        logic [11:0] i12;
        logic [4:0]  r5;
        i12 = 12'(100 + k);
        r5  = 5'(k + 1);
        return {i12, 5'd0, 3'd0, r5, 7'h13};
    endfunction

    initial begin
        int k;
        int n;
        logic acc;
        logic cons;
        logic stall;
        logic model_skid;
        logic [159:0] snap;

        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        instr    = 32'h0;
        pc       = 32'h0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;

        // instr, pc, rs1, rs2, ctrl, a, b, imm, rd, rw, br, mr, mw, ill
        vq.push_back('{32'h002081B3, 32'h000, 32'd4, 32'd5, 6'b000000,
                       32'd4, 32'd5, 32'h0, 5'd3, 1, 0, 0, 0, 0});
        vq.push_back('{32'h402081B3, 32'h004, 32'd4, 32'd5, 6'b001000,
                       32'd4, 32'd5, 32'h0, 5'd3, 1, 0, 0, 0, 0});
        vq.push_back('{32'h0020C1B3, 32'h006, 32'hF0, 32'h0F, 6'b000100,
                       32'hF0, 32'h0F, 32'h0, 5'd3, 1, 0, 0, 0, 0});
        vq.push_back('{32'h40335293, 32'h008, 32'hFFFFFFBE, 32'd0, 6'b001101,
                       32'hFFFFFFBE, 32'd3, 32'h403, 5'd5, 1, 0, 0, 0, 0});
        vq.push_back('{32'hFFF00093, 32'h00C, 32'd0, 32'd0, 6'b000000,
                       32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1, 0, 0, 0, 0});
        vq.push_back('{32'h40008113, 32'h010, 32'hA, 32'd0, 6'b000000,
                       32'hA, 32'h400, 32'h400, 5'd2, 1, 0, 0, 0, 0});
        vq.push_back('{32'h01F09093, 32'h014, 32'd1, 32'd0, 6'b000001,
                       32'd1, 32'h1F, 32'h1F, 5'd1, 1, 0, 0, 0, 0});
        vq.push_back('{32'h0020D463, 32'h100, 32'd32, 32'd31, 6'b010101,
                       32'd32, 32'd31, 32'd8, 5'd0, 0, 1, 0, 0, 0});
        vq.push_back('{32'h000280E7, 32'h040, 32'h1234, 32'd0, 6'b111111,
                       32'h44, 32'h0, 32'h0, 5'd1, 1, 0, 0, 0, 0});
        vq.push_back('{32'h123453B7, 32'h050, 32'd9, 32'd0, 6'b000000,
                       32'h0, 32'h12345000, 32'h12345000, 5'd7, 1, 0, 0, 0, 0});
        vq.push_back('{32'h00001217, 32'h200, 32'd0, 32'd0, 6'b000000,
                       32'h200, 32'h1000, 32'h1000, 5'd4, 1, 0, 0, 0, 0});
        vq.push_back('{32'hFFC12303, 32'h060, 32'h1000, 32'd0, 6'b000000,
                       32'h1000, 32'hFFFFFFFC, 32'hFFFFFFFC, 5'd6, 1, 0, 1, 0, 0});
        vq.push_back('{32'h0050A423, 32'h064, 32'h2000, 32'd99, 6'b000000,
                       32'h2000, 32'd8, 32'd8, 5'd0, 0, 0, 0, 1, 0});
        vq.push_back('{32'h0100006F, 32'h300, 32'd0, 32'd0, 6'b111111,
                       32'h304, 32'h10, 32'h10, 5'd0, 0, 0, 0, 0, 0});
        vq.push_back('{32'h0000007F, 32'h070, 32'd7, 32'd8, 6'b000000,
                       32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1});

        // Reset state
        #1;
        check("reset_outputs", snapshot(), 160'd0);
        check("reset_in_ready", in_ready, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Decode table, one instruction per cycle at full throughput
        for (int i = 0; i < vq.size(); i++) begin
            in_valid = 1'b1;
            instr    = vq[i].instr;
            pc       = vq[i].pc;
            rs1_data = vq[i].rs1;
            rs2_data = vq[i].rs2;
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_ops", i), {out_valid, ALU_Control, operand_A, operand_B},
                  {1'b1, vq[i].ctrl, vq[i].a, vq[i].b});
            check($sformatf("vec%0d_ctl", i),
                  {imm, pc_out, rd, reg_write, branch_op, mem_read, mem_write, illegal},
                  {vq[i].imm, vq[i].pc, vq[i].rd, vq[i].rw, vq[i].br, vq[i].mr, vq[i].mw,
                   vq[i].ill});
        end
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("idle_after_table", out_valid, 1'b0);

        // Four-instruction stream, out_ready low for the first stalled cycles
        k = 0;
        n = 0;
        model_skid = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (k < 4);
            instr     = addi_instr(k);
            pc        = 32'h1000 + 32'(4 * k);
            rs1_data  = 32'd0;
            rs2_data  = 32'd0;
            #1;
            acc   = in_valid && in_ready;
            cons  = out_valid && out_ready;
            stall = out_valid && !out_ready;
            snap  = snapshot();
`ifdef ALU_DECODE_SKID_EN
            check("skid_in_ready", in_ready, !model_skid);
            if (model_skid && (!out_valid || out_ready)) model_skid = 1'b0;
            else if (stall && acc) model_skid = 1'b1;
`else
            if (stall) check("stall_in_ready", in_ready, 1'b0);
`endif
            if (cons) begin
                check($sformatf("stream_order%0d", n), {rd, operand_B, pc_out},
                      {5'(n + 1), 32'(100 + n), 32'h1000 + 32'(4 * n)});
                n++;
            end
            @(posedge clock);
            #1;
            if (acc) k++;
            if (stall) check("stall_hold", snapshot(), snap);
        end
        if (n != 4) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d outputs required 4", n);
        end
        in_valid = 1'b0;
        #1;
        check("stream_no_dup", out_valid, 1'b0);

        // Flush with a valid output and a same-cycle input
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'h002081B3;
        rs1_data  = 32'd4;
        rs2_data  = 32'd5;
        @(posedge clock);
        #1;
        check("pre_flush_valid", out_valid, 1'b1);
        flush = 1'b1;
        instr = 32'hFFF00093;
        @(posedge clock);
        #1;
        check("flush_clears_valid", out_valid, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("flush_drops_input", out_valid, 1'b0);

        // Async reset mid-transfer
        in_valid = 1'b1;
        instr    = 32'h002081B3;
        pc       = 32'h500;
        @(posedge clock);
        #1;
        check("pre_reset_valid", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_clear", snapshot(), 160'd0);
        check("reset_async_in_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("reset_no_capture", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
